// File: rtl/modular_exponentiation.sv
// Right-to-left square-and-multiply modular exponentiation that issues one request at a time
// to an external modular multiplier over valid/ready handshakes.
module modular_exponentiation #(
  parameter int unsigned SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_base_tdata,
  input  logic [SIZE-1:0] input_exponent_tdata,
  input  logic [SIZE-1:0] input_modulus_tdata,
  input  logic            input_tvalid,
  output logic            input_tready,
  output logic [SIZE-1:0] mul_multiplier_tdata,
  output logic [SIZE-1:0] mul_multiplicand_tdata,
  output logic [SIZE-1:0] mul_modulus_tdata,
  output logic            mul_tvalid,
  input  logic            mul_tready,
  input  logic [SIZE-1:0] mul_result_tdata,
  input  logic            mul_result_tvalid,
  output logic            mul_result_tready,
  output logic [SIZE-1:0] output_tdata,
  output logic            output_tvalid,
  input  logic            output_tready,
  output logic            output_error
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] RED_REQ  = 4'd1;
  localparam logic [3:0] RED_WAIT = 4'd2;
  localparam logic [3:0] CHECK    = 4'd3;
  localparam logic [3:0] MUL_REQ  = 4'd4;
  localparam logic [3:0] MUL_WAIT = 4'd5;
  localparam logic [3:0] SQR_REQ  = 4'd6;
  localparam logic [3:0] SQR_WAIT = 4'd7;
  localparam logic [3:0] DONE     = 4'd8;

  logic [3:0]      state_q, state_d;
  logic [SIZE-1:0] r_q, r_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [SIZE-1:0] e_q, e_d;
  logic [SIZE-1:0] m_q, m_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    b_d     = b_q;
    e_d     = e_q;
    m_d     = m_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (input_tvalid) begin
          b_d = input_base_tdata;
          e_d = input_exponent_tdata;
          m_d = input_modulus_tdata;
          // Modulus 0/1 has a trivial answer; no multiplier traffic at all.
          if (input_modulus_tdata <= SIZE'(1)) begin
            r_d     = '0;
            err_d   = (input_modulus_tdata == '0);
            state_d = DONE;
          end else begin
            r_d     = SIZE'(1);
            err_d   = 1'b0;
            state_d = RED_REQ;
          end
        end
      end
      RED_REQ:  if (mul_tready) state_d = RED_WAIT;
      RED_WAIT: begin
        if (mul_result_tvalid) begin
          b_d     = mul_result_tdata;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (e_q == '0)    state_d = DONE;
        else if (e_q[0])  state_d = MUL_REQ;
        else              state_d = SQR_REQ;
      end
      MUL_REQ:  if (mul_tready) state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mul_result_tvalid) begin
          r_d     = mul_result_tdata;
          // Skip the square that would follow the last set exponent bit.
          state_d = (e_q[SIZE-1:1] != '0) ? SQR_REQ : DONE;
        end
      end
      SQR_REQ:  if (mul_tready) state_d = SQR_WAIT;
      SQR_WAIT: begin
        if (mul_result_tvalid) begin
          b_d     = mul_result_tdata;
          e_d     = e_q >> 1;
          state_d = CHECK;
        end
      end
      DONE:     if (output_tready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      b_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      b_q     <= b_d;
      e_q     <= e_d;
      m_q     <= m_d;
      err_q   <= err_d;
    end
  end

  // Operand buses are a pure function of state and registers, so they hold while stalled.
  always_comb begin
    mul_multiplier_tdata   = '0;
    mul_multiplicand_tdata = '0;
    mul_modulus_tdata      = '0;
    case (state_q)
      RED_REQ, RED_WAIT: begin
        mul_multiplier_tdata   = b_q;
        mul_multiplicand_tdata = SIZE'(1);
        mul_modulus_tdata      = m_q;
      end
      MUL_REQ, MUL_WAIT: begin
        mul_multiplier_tdata   = r_q;
        mul_multiplicand_tdata = b_q;
        mul_modulus_tdata      = m_q;
      end
      SQR_REQ, SQR_WAIT: begin
        mul_multiplier_tdata   = b_q;
        mul_multiplicand_tdata = b_q;
        mul_modulus_tdata      = m_q;
      end
      default: ;
    endcase
  end

  assign input_tready      = (state_q == IDLE);
  assign mul_tvalid        = (state_q == RED_REQ) || (state_q == MUL_REQ) || (state_q == SQR_REQ);
  assign mul_result_tready = (state_q == RED_WAIT) || (state_q == MUL_WAIT) ||
                             (state_q == SQR_WAIT);
  assign output_tvalid     = (state_q == DONE);
  assign output_tdata      = r_q;
  assign output_error      = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_modular_exponentiation.sv
// Directed bench for modular_exponentiation with a behavioural multiplier that can stall
// both its request and result handshakes.
module tb_modular_exponentiation;

  localparam int unsigned SIZE = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] input_base_tdata, input_exponent_tdata, input_modulus_tdata;
  logic            input_tvalid, input_tready;
  logic [SIZE-1:0] mul_multiplier_tdata, mul_multiplicand_tdata, mul_modulus_tdata;
  logic            mul_tvalid;
  logic            mul_tready;
  logic [SIZE-1:0] mul_result_tdata;
  logic            mul_result_tvalid, mul_result_tready;
  logic [SIZE-1:0] output_tdata;
  logic            output_tvalid, output_tready, output_error;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  logic stall_en = 1'b0;

  logic            pending;
  int unsigned     lat;
  logic [SIZE-1:0] prod;

  always #5 clk = ~clk;

  modular_exponentiation #(.SIZE(SIZE)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .input_base_tdata       (input_base_tdata),
    .input_exponent_tdata   (input_exponent_tdata),
    .input_modulus_tdata    (input_modulus_tdata),
    .input_tvalid           (input_tvalid),
    .input_tready           (input_tready),
    .mul_multiplier_tdata   (mul_multiplier_tdata),
    .mul_multiplicand_tdata (mul_multiplicand_tdata),
    .mul_modulus_tdata      (mul_modulus_tdata),
    .mul_tvalid             (mul_tvalid),
    .mul_tready             (mul_tready),
    .mul_result_tdata       (mul_result_tdata),
    .mul_result_tvalid      (mul_result_tvalid),
    .mul_result_tready      (mul_result_tready),
    .output_tdata           (output_tdata),
    .output_tvalid          (output_tvalid),
    .output_tready          (output_tready),
    .output_error           (output_error)
  );

  // Modular multiplier model; reset drops any product still in flight.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_tready        <= 1'b0;
      mul_result_tvalid <= 1'b0;
      mul_result_tdata  <= '0;
      pending           <= 1'b0;
      lat               <= 0;
      prod              <= '0;
    end else begin
      mul_tready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mul_tvalid && mul_tready) begin
        req_cnt <= req_cnt + 1;
        pending <= 1'b1;
        lat     <= stall_en ? $urandom_range(0, 3) : 0;
        prod    <= SIZE'((128'(mul_multiplier_tdata) * 128'(mul_multiplicand_tdata)) %
                         128'(mul_modulus_tdata));
      end
      if (pending && !mul_result_tvalid) begin
        if (lat == 0) begin
          mul_result_tvalid <= 1'b1;
          mul_result_tdata  <= prod;
        end else begin
          lat <= lat - 1;
        end
      end
      if (mul_result_tvalid && mul_result_tready) begin
        mul_result_tvalid <= 1'b0;
        pending           <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presents one job and returns at the negedge after the input transfer.
  task automatic send(input logic [SIZE-1:0] base, input logic [SIZE-1:0] expo,
                      input logic [SIZE-1:0] modu);
    int i;
    input_base_tdata     = base;
    input_exponent_tdata = expo;
    input_modulus_tdata  = modu;
    input_tvalid         = 1'b1;
    for (i = 0; i < 50 && !input_tready; i++) @(negedge clk);
    if (!input_tready) check("send_timeout", 64'(input_tready), 64'd1);
    @(negedge clk);
    input_tvalid = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [SIZE-1:0] base,
                         input logic [SIZE-1:0] expo, input logic [SIZE-1:0] modu,
                         input int hold, input logic [SIZE-1:0] exp_out, input logic exp_err,
                         input int exp_reqs);
    int cnt0;
    int cyc;
    logic prev_hold;
    logic [SIZE-1:0] pa, pb, pm;
    cnt0 = req_cnt;
    send(base, expo, modu);
    check({tag, "_busy_tready"}, 64'(input_tready), 64'd0);
    prev_hold = 1'b0;
    pa = '0; pb = '0; pm = '0;
    cyc = 0;
    while (!output_tvalid && cyc < 3000) begin
      if (prev_hold) begin
        check({tag, "_req_held"}, 64'(mul_tvalid), 64'd1);
        check({tag, "_req_stable"}, mul_multiplier_tdata ^ pa ^ mul_multiplicand_tdata ^ pb,
              64'd0);
        check({tag, "_mod_stable"}, mul_modulus_tdata, pm);
      end
      prev_hold = mul_tvalid && !mul_tready;
      pa = mul_multiplier_tdata;
      pb = mul_multiplicand_tdata;
      pm = mul_modulus_tdata;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_valid"}, 64'(output_tvalid), 64'd1);
    check({tag, "_out"}, output_tdata, exp_out);
    check({tag, "_err"}, 64'(output_error), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(output_tvalid), 64'd1);
      check({tag, "_hold_out"}, output_tdata, exp_out);
      check({tag, "_hold_err"}, 64'(output_error), 64'(exp_err));
    end
    output_tready = 1'b1;
    @(negedge clk);
    output_tready = 1'b0;
    check({tag, "_released"}, 64'(output_tvalid), 64'd0);
    check({tag, "_idle"}, 64'(input_tready), 64'd1);
    check({tag, "_reqs"}, 64'(req_cnt - cnt0), 64'(exp_reqs));
  endtask

  initial begin
    int i;
    rst                  = 1'b0;
    input_tvalid         = 1'b0;
    input_base_tdata     = '0;
    input_exponent_tdata = '0;
    input_modulus_tdata  = '0;
    output_tready        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(input_tready), 64'd1);
    check("rst_mul_valid", 64'(mul_tvalid), 64'd0);
    check("rst_res_ready", 64'(mul_result_tready), 64'd0);
    check("rst_out_valid", 64'(output_tvalid), 64'd0);
    check("rst_out_err", 64'(output_error), 64'd0);
    check("rst_out_data", output_tdata, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_job("b3e5m7", 64'd3, 64'd5, 64'd7, 0, 64'd5, 1'b0, 5);
    run_job("b5e0m13", 64'd5, 64'd0, 64'd13, 0, 64'd1, 1'b0, 1);
    run_job("b10e3m7", 64'd10, 64'd3, 64'd7, 0, 64'd6, 1'b0, 4);
    run_job("m0", 64'd9, 64'd4, 64'd0, 2, 64'd0, 1'b1, 0);
    run_job("m1", 64'd9, 64'd4, 64'd1, 0, 64'd0, 1'b0, 0);
    run_job("b7e13m11", 64'd7, 64'd13, 64'd11, 0, 64'd2, 1'b0, 7);

    stall_en = 1'b1;
    run_job("stall_b3e5m7", 64'd3, 64'd5, 64'd7, 10, 64'd5, 1'b0, 5);
    run_job("stall_b10e3m7", 64'd10, 64'd3, 64'd7, 10, 64'd6, 1'b0, 4);
    run_job("stall_b7e13m11", 64'd7, 64'd13, 64'd11, 3, 64'd2, 1'b0, 7);
    stall_en = 1'b0;

    // Exponent 4 is even, so the first request with equal operands is the first square.
    send(64'd3, 64'd4, 64'd100);
    for (i = 0; i < 100; i++) begin
      if (mul_tvalid && mul_tready && mul_multiplier_tdata == mul_multiplicand_tdata) break;
      @(negedge clk);
    end
    check("sqr_req_seen", 64'(i < 100), 64'd1);
    @(negedge clk);
    check("sqr_wait_ready", 64'(mul_result_tready), 64'd1);
    rst = 1'b0;
    #1;
    check("arst_mul_valid", 64'(mul_tvalid), 64'd0);
    check("arst_res_ready", 64'(mul_result_tready), 64'd0);
    check("arst_out_valid", 64'(output_tvalid), 64'd0);
    check("arst_out_data", output_tdata, 64'd0);
    check("arst_in_ready", 64'(input_tready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_job("b2e10m1000", 64'd2, 64'd10, 64'd1000, 0, 64'd24, 1'b0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modular_exponentiation.md
MODULAR_EXPONENTIATION -- requirements
Module: modular_exponentiation

Interface
REQ-001 Parameter SHALL be: SIZE, 64, operand/result width in bits.
REQ-002 Port clk SHALL be: input, 1, single clock; all state changes on rising edge.
REQ-003 Port rst SHALL be: input, 1, reset, asynchronous and active-low.
REQ-004 Ports input_base_tdata, input_exponent_tdata, input_modulus_tdata SHALL be: input, SIZE each, job operands.
REQ-005 Port input_tvalid SHALL be: input, 1, job valid. Port input_tready SHALL be: output, 1, job accept.
REQ-006 Ports mul_multiplier_tdata, mul_multiplicand_tdata, mul_modulus_tdata SHALL be: output, SIZE each, request to the downstream modular multiplier.
REQ-007 Port mul_tvalid SHALL be: output, 1, request valid. Port mul_tready SHALL be: input, 1, request accept.
REQ-008 Port mul_result_tdata SHALL be: input, SIZE, product mod modulus. Port mul_result_tvalid SHALL be: input, 1, product valid. Port mul_result_tready SHALL be: output, 1, product accept.
REQ-009 Port output_tdata SHALL be: output, SIZE, base^exponent mod modulus. Port output_tvalid SHALL be: output, 1, result valid. Port output_tready SHALL be: input, 1, result accept.
REQ-010 Port output_error SHALL be: output, 1, qualified by output_tvalid; high when modulus==0.

Function
REQ-011 The block SHALL compute right-to-left square-and-multiply with registers R (result), B (base power), E (remaining exponent), M (modulus), issuing one multiplier operation at a time.
REQ-012 The states SHALL be IDLE, RED_REQ, RED_WAIT, CHECK, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE.
REQ-013 input_tready SHALL be high only in IDLE; a transfer (input_tvalid & input_tready) SHALL latch B, E and M, set R=1, and move to RED_REQ.
REQ-014 If the latched modulus is 0 or 1, the block SHALL skip all multiplier operations and go to DONE with R=0; output_error SHALL be 1 only for modulus 0.
REQ-015 RED_REQ SHALL present (B, 1, M) with mul_tvalid=1 until mul_tready; RED_WAIT SHALL load B from the product (base reduction, so base >= modulus is legal).
REQ-016 CHECK SHALL go to DONE if E==0; else MUL_REQ if E[0]==1; else SQR_REQ.
REQ-017 MUL_REQ/MUL_WAIT SHALL present (R, B, M) and load R from the product; then SQR_REQ if (E>>1)!=0, else DONE (the final square is skipped).
REQ-018 SQR_REQ/SQR_WAIT SHALL present (B, B, M), load B from the product, shift E right by 1, and return to CHECK.
REQ-019 mul_tvalid SHALL be high only in *_REQ states, with the data buses stable while it is high and unaccepted.
REQ-020 mul_result_tready SHALL be high only in *_WAIT states; products arriving in any other state SHALL be ignored.
REQ-021 Multiplier latency SHALL be arbitrary; all progress SHALL be handshake-driven, never cycle-counted.
REQ-022 DONE SHALL hold output_tvalid=1 with stable output_tdata and output_error until output_tready, then return to IDLE the same edge.
REQ-023 At most 2*SIZE+1 multiplier operations SHALL be issued per job.

Reset
REQ-024 While rst is low: state=IDLE; input_tready=1 after release; mul_tvalid, mul_result_tready, output_tvalid, output_error=0; all data registers cleared.
REQ-025 Reset asserted mid-job SHALL abandon the job immediately, including any outstanding multiplier result.

Verification
REQ-026 base=3, exp=5, mod=7 -> output 5, error 0, exactly 5 mul requests (reduce, mul, sqr, sqr, mul).
REQ-027 base=5, exp=0, mod=13 -> output 1 after one reduce request only.
REQ-028 base=10, exp=3, mod=7 -> output 6 (base reduced to 3 first).
REQ-029 mod=0 -> output 0, error 1, zero mul requests; mod=1 -> output 0, error 0.
REQ-030 Random mul_tready/mul_result_tvalid stalls and output_tready held low 10 cycles -> identical results, outputs stable while stalled, no lost or duplicated requests.
REQ-031 rst pulsed low during SQR_WAIT -> outputs reset asynchronously; next job base=2, exp=10, mod=1000 -> output 24.
